// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch queue.
package fetch_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] PC_STEP  = 32'd4;

    // IDLE: nothing outstanding; WAIT: result kept; DRAIN: result discarded.
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} fetch_state_e;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, insn} entries. Flush beats push and pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues word fetches over req/ack, buffers returned
// words with their PCs and presents them to the core over valid/ready.
// Define FETCH_PERF_EN to build the fetched/flushed performance counters.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q;
    logic [31:0]      fetch_pc_q;
    logic             imem_req_q;
    logic [31:0]      imem_addr_q;
    logic [63:0]      fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             room;
    logic [31:0]      next_pc;
    logic [31:0]      target_pc;

    assign pop        = inst_ready & ~fifo_empty;
    assign push       = (state_q == WAIT) & imem_ack & ~redirect;
    assign next_pc    = fetch_pc_q + PC_STEP;
    assign target_pc  = word_align(redirect_pc);
    // Occupancy after this cycle's push; another request is safe only below DEPTH.
    assign count_next = fifo_count + CNT_W'(1) - CNT_W'(pop);
    assign room       = (count_next < CNT_W'(DEPTH));

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({fetch_pc_q, imem_rdata}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Fetch FSM with registered request outputs; a request is never abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc_q <= target_pc;
                    end else if (!fifo_full) begin
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fetch_pc_q;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc_q <= target_pc;
                        if (imem_ack) begin
                            imem_req_q <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        fetch_pc_q <= next_pc;
                        if (room) begin
                            imem_addr_q <= next_pc;
                        end else begin
                            imem_req_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (redirect) fetch_pc_q <= target_pc;
                    if (imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    imem_req_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign inst_valid = ~fifo_empty;
    assign inst_out   = fifo_empty ? NOP_INSN : fifo_rdata[31:0];
    assign inst_pc    = fifo_empty ? 32'h0 : fifo_rdata[63:32];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    // Count accepted words and redirect cycles; both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (push)     perf_fetched_q <= perf_fetched_q + 32'd1;
            if (redirect) perf_flushed_q <= perf_flushed_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`else
    assign perf_fetched = 32'd0;
    assign perf_flushed = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a random
// traffic phase checked against a stream-level model of the fetch queue.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;

    int vectors     = 0;
    int miscompares = 0;
    int lat_fixed   = 0;
    bit lat_rand    = 0;
    int ack_count   = 0;
    int consumed    = 0;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_out     (inst_out),
        .inst_pc      (inst_pc),
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Stream model and memory responder, both at the falling edge.
    // Model: the core must see consecutive words from the last redirect target
    // (or reset PC), each with the memory word at that PC, nothing after a flush.
    initial begin
        logic [31:0] exp_pc;
        logic [31:0] held_addr;
        bit          redir_seen;
        bit          pending;
        bit          held;
        int          lat_left;
        exp_pc     = 32'h0;
        held_addr  = 32'h0;
        redir_seen = 0;
        pending    = 0;
        held       = 0;
        lat_left   = 0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_pc     = 32'h0;
                redir_seen = 0;
                pending    = 0;
                held       = 0;
                imem_ack   = 1'b0;
            end else begin
                if (redir_seen) begin
                    vectors++;
                    if (inst_valid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL flush_valid: got %b want 0", inst_valid);
                    end
                end
                if (inst_valid === 1'b1) begin
                    if (inst_ready === 1'b1) begin
                        vectors++;
                        if (inst_pc !== exp_pc || inst_out !== mem_word(exp_pc)) begin
                            miscompares++;
                            $display("FAIL stream: got pc %h insn %h want pc %h insn %h",
                                     inst_pc, inst_out, exp_pc, mem_word(exp_pc));
                        end
                        exp_pc = exp_pc + 32'd4;
                        consumed++;
                    end
                end else begin
                    vectors++;
                    if (inst_out !== NOP || inst_pc !== 32'h0) begin
                        miscompares++;
                        $display("FAIL empty_outputs: got insn %h pc %h want %h 0",
                                 inst_out, inst_pc, NOP);
                    end
                end
                if (held) begin
                    vectors++;
                    if (imem_req !== 1'b1 || imem_addr !== held_addr) begin
                        miscompares++;
                        $display("FAIL req_hold: got req %b addr %h want 1 %h",
                                 imem_req, imem_addr, held_addr);
                    end
                end
                if (redirect === 1'b1) exp_pc = redirect_pc & 32'hFFFF_FFFC;
                redir_seen = (redirect === 1'b1);

                if (imem_req !== 1'b1) begin
                    imem_ack = 1'b0;
                    pending  = 0;
                    held     = 0;
                end else begin
                    if (!pending) begin
                        pending  = 1;
                        lat_left = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
                    end
                    if (lat_left == 0) begin
                        imem_ack   = 1'b1;
                        imem_rdata = mem_word(imem_addr);
                        pending    = 0;
                        held       = 0;
                        ack_count++;
                    end else begin
                        imem_ack   = 1'b0;
                        imem_rdata = $urandom;
                        lat_left--;
                        held       = 1;
                        held_addr  = imem_addr;
                    end
                end
            end
        end
    end

    // Reset for two edges, release just after a rising edge, stop at the next falling edge.
    task automatic reset_dut();
        rst_n    = 1'b0;
        redirect = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Bounded wait for inst_valid at falling edges.
    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        redirect   = 1'b0;
        inst_ready = 1'b0;
        lat_fixed  = 0;
        lat_rand   = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_req: got %b %h want 0 00000000", imem_req, imem_addr);
        end
        vectors++;
        if (inst_valid !== 1'b0 || inst_out !== NOP || inst_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_inst: got %b %h %h want 0 %h 0", inst_valid, inst_out,
                     inst_pc, NOP);
        end
        vectors++;
        if (perf_fetched !== 32'h0 || perf_flushed !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_perf: got %h %h want 0 0", perf_fetched, perf_flushed);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_early_req: got %b want 0", imem_req);
        end
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_first_req: got %b %h want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        lat_fixed  = 0;
        lat_rand   = 0;
        inst_ready = 1'b1;
        reset_dut();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1))) begin
                miscompares++;
                $display("FAIL stream_addr[%0d]: got %b %h want 1 %h", k, imem_req, imem_addr,
                         32'(4 * (k - 1)));
            end
            if (k >= 2) begin
                vectors++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (k - 2))) begin
                    miscompares++;
                    $display("FAIL stream_head[%0d]: got %b %h want 1 %h", k, inst_valid,
                             inst_pc, 32'(4 * (k - 2)));
                end
            end
        end
    endtask

    task automatic test_full();
        bit ok;
        lat_fixed  = 0;
        lat_rand   = 0;
        inst_ready = 1'b0;
        reset_dut();
        ack_count = 0;
        repeat (10) @(negedge clk);
        vectors++;
        if (ack_count != DEPTH || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL full_fill: got %0d words req %b want %0d words req 0", ack_count,
                     imem_req, DEPTH);
        end
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL full_head: got %b %h want 1 00000000", inst_valid, inst_pc);
        end
        @(posedge clk); #1;
        inst_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                ok = 1;
                break;
            end
        end
        vectors++;
        if (!ok || imem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL full_resume: got req seen %0d addr %h want 1 00000010", ok,
                     imem_addr);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_drain();
        bit ok;
        lat_fixed  = 3;
        lat_rand   = 0;
        inst_ready = 1'b1;
        reset_dut();
        @(posedge clk);
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL drain_hold: got %b %h want 1 00000000", imem_req, imem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_drop: got req %b valid %b want 0 0", imem_req, inst_valid);
        end
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL drain_refetch: got %b %h want 1 00000100", imem_req, imem_addr);
        end
        wait_valid(ok);
        vectors++;
        if (!ok || inst_pc !== 32'h100 || inst_out !== mem_word(32'h100)) begin
            miscompares++;
            $display("FAIL drain_first: got ok %0d pc %h insn %h want 1 00000100 %h", ok,
                     inst_pc, inst_out, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_ack_pop();
        bit ok;
        lat_fixed  = 0;
        lat_rand   = 0;
        inst_ready = 1'b0;
        reset_dut();
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        inst_ready  = 1'b1;
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_valid !== 1'b1 ||
            inst_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL rap_setup: got req %b addr %h valid %b pc %h want 1 8 1 0",
                     imem_req, imem_addr, inst_valid, inst_pc);
        end
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        vectors++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rap_flush: got valid %b req %b want 0 0", inst_valid, imem_req);
        end
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL rap_refetch: got %b %h want 1 00000200", imem_req, imem_addr);
        end
        wait_valid(ok);
        vectors++;
        if (!ok || inst_pc !== 32'h200) begin
            miscompares++;
            $display("FAIL rap_first: got ok %0d pc %h want 1 00000200", ok, inst_pc);
        end
    endtask

    task automatic test_wrap();
        lat_fixed  = 0;
        lat_rand   = 0;
        inst_ready = 1'b1;
        reset_dut();
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_discard: got req %b want 0", imem_req);
        end
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_addr: got %b %h want 1 fffffffc", imem_req, imem_addr);
        end
        @(negedge clk);
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_first: got valid %b pc %h addr %h want 1 fffffffc 0",
                     inst_valid, inst_pc, imem_addr);
        end
        @(negedge clk);
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== mem_word(32'h0)) begin
            miscompares++;
            $display("FAIL wrap_second: got %b %h %h want 1 0 %h", inst_valid, inst_pc,
                     inst_out, mem_word(32'h0));
        end
    endtask

    task automatic test_perf();
        logic [31:0] exp_fetched;
        logic [31:0] exp_flushed;
`ifdef FETCH_PERF_EN
        exp_fetched = 32'd10;
        exp_flushed = 32'd2;
`else
        exp_fetched = 32'd0;
        exp_flushed = 32'd0;
`endif
        lat_fixed  = 0;
        lat_rand   = 0;
        inst_ready = 1'b1;
        reset_dut();
        repeat (11) @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        @(posedge clk); #1;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        vectors++;
        if (perf_fetched !== exp_fetched || perf_flushed !== exp_flushed) begin
            miscompares++;
            $display("FAIL perf: got %0d %0d want %0d %0d", perf_fetched, perf_flushed,
                     exp_fetched, exp_flushed);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit ok;
        lat_fixed  = 0;
        lat_rand   = 1;
        inst_ready = 1'b1;
        reset_dut();
        repeat (8) @(negedge clk);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #3;
            if (imem_req === 1'b1 && inst_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (!ok || imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0 ||
            inst_out !== NOP || inst_pc !== 32'h0 || perf_fetched !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: got busy %0d req %b addr %h valid %b insn %h pc %h",
                     ok, imem_req, imem_addr, inst_valid, inst_out, inst_pc);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int start;
        lat_rand = 1;
        reset_dut();
        start = consumed;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 31) == 0);
            redirect_pc = $urandom;
        end
        @(posedge clk); #1;
        redirect = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (consumed - start < 100) begin
            miscompares++;
            $display("FAIL random_progress: got %0d words want at least 100", consumed - start);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_drain();
        test_redirect_ack_pop();
        test_wrap();
        test_perf();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction fetch stage directly upstream of the single-cycle RISC-V core.
- Issues word fetches to a multi-cycle instruction memory over a req/ack handshake and buffers returned words, each with its PC, in a small prefetch FIFO.
- Presents words to the core over valid/ready.
- Core redirects (taken branch, jal, jalr) flush the queue and restart fetch at the new PC. In-flight responses are discarded.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- redirect  in  1  core requests fetch restart this cycle.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  32  word address of request; stable while imem_req=1.
- imem_ack  in  1  response valid this cycle; only meaningful while imem_req=1.
- imem_rdata  in  32  instruction word, sampled when imem_ack=1.
- inst_valid  out  1  inst_out/inst_pc hold a valid queued instruction.
- inst_ready  in  1  core consumes head entry when inst_valid&inst_ready.
- inst_out  out  32  head instruction; 32'h0000_0013 (NOP) when empty.
- inst_pc  out  32  PC of head instruction; 0 when empty.
- perf_fetched  out  32  see Optional Feature.
- perf_flushed  out  32  see Optional Feature.

Behaviour:
- Reset values: imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, state=IDLE, FIFO count=0, inst_valid=0, inst_out=NOP, inst_pc=0, perf counters=0.
- FSM has three states, all outputs registered:
  - IDLE: no request outstanding. If no redirect and count<DEPTH, set imem_req=1 with imem_addr=fetch_pc and go to WAIT.
  - WAIT: request outstanding and the result will be kept.
  - DRAIN: request outstanding and the result will be discarded. Requests are never abandoned mid-handshake.
- WAIT with ack and no redirect:
  - Push {fetch_pc, imem_rdata} and set fetch_pc += 4 (wraps modulo 2^32).
  - Compute count_next = count + 1 - pop.
  - If count_next < DEPTH: stay in WAIT, keep imem_req=1, imem_addr = new fetch_pc (back-to-back, one word per cycle with zero-wait memory).
  - Otherwise: drop imem_req and go to IDLE.
- WAIT with redirect, no ack: go to DRAIN; fetch_pc = redirect_pc; imem_req stays 1 and imem_addr unchanged.
- WAIT with redirect and ack in the same cycle: discard the data, fetch_pc = redirect_pc, drop imem_req, go to IDLE.
- DRAIN with ack: discard the data, drop imem_req, go to IDLE. A redirect in the same cycle updates fetch_pc.
- DRAIN with redirect, no ack: stay in DRAIN; fetch_pc = redirect_pc (latest redirect wins).
- IDLE with redirect: fetch_pc = redirect_pc. No request is issued that cycle; the request goes out the following cycle.
- Flush: any redirect clears the FIFO (count=0, pointers=0) at that edge. Flush overrides a simultaneous pop or push. inst_valid=0 the cycle after redirect.
- Latency: ack at edge N makes the entry visible on inst_valid at N+1. From reset release, the first imem_req is asserted after the first clk edge.
- Full: count never exceeds DEPTH. A new request is issued only if the push cannot overflow.
- Empty: inst_valid=0; pop is ignored.
- Simultaneous push and pop: both occur and count is unchanged.
- Pointers wrap modulo DEPTH.
- Asynchronous reset mid-transaction returns to reset values immediately. The memory must tolerate imem_req dropping without an ack on reset.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - perf_fetched increments on every accepted (pushed) word.
  - perf_flushed increments on every redirect cycle.
  - Both are 32-bit, wrap, and are cleared by rst_n.
- Undefined: both ports are tied to 32'd0 and no counter flops exist.

Decomposition:
- Package fetch_pkg contains:
  - NOP_INSN = 32'h0000_0013.
  - PC_STEP = 4.
  - State enum {IDLE, WAIT, DRAIN}.
- Sub-module fetch_fifo: synchronous FIFO of {pc[31:0], insn[31:0]} with push, pop, flush, count, full and empty. Flush has priority.

Test Plan:
1. Reset, zero-wait ack, inst_ready=1 → imem_addr sequence 0,4,8,…; inst_pc follows one cycle behind with matching imem_rdata; inst_valid continuous after first word.
2. inst_ready=0, DEPTH=4, ack always 1 → exactly 4 words pushed (PCs 0..12); imem_req drops; inst_valid stays 1 with inst_pc=0; raise inst_ready → fetch resumes at 16.
3. Redirect to 0x100 while WAIT with ack delayed 3 cycles → FSM enters DRAIN; returned word is never presented; next imem_addr=0x100; first inst_pc=0x100.
4. Redirect to 0x200 in the same cycle as ack and pop, FIFO holding 2 entries → FIFO empties, inst_valid=0 next cycle, next request address 0x200.
5. Redirect_pc=0xFFFF_FFFC, zero-wait memory → fetched PCs 0xFFFF_FFFC then 0x0000_0000 (wrap).
6. With FETCH_PERF_EN: 10 words fetched and 2 redirects → perf_fetched=10 (excluding discarded words), perf_flushed=2. Without the macro both read 0.
